ct_f_spsram_4096x84_ctrl: RTL
=============================

CT_F_SPSRAM_4096X84_CTRL -- requirements
Module: ct_f_spsram_4096x84_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 12, SRAM address bits; DATA_WIDTH, default 84, data bits; INIT_VAL, default 0, word written at init.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL have ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- init_done  out  1  array initialized; request port live.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  per-bit write enable, 1=write.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  read data consumed when rsp_vld & rsp_rdy.
- rsp_rdata  out  DATA_WIDTH  read data.
- A  out  ADDR_WIDTH  SRAM address.
- CEN  out  1  SRAM chip enable, active-low.
- D  out  DATA_WIDTH  SRAM write data.
- GWEN  out  1  SRAM global write enable, active-low.
- WEN  out  DATA_WIDTH  SRAM bit write enables, active-low.
- Q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

Function
REQ-004 SHALL implement FSM states INIT and RUN; reset enters INIT with init counter 0.
REQ-005 SHALL behave in INIT as follows each cycle:
- drive CEN=0, GWEN=0, WEN=all 0, D=INIT_VAL, A=counter;
- increment the counter;
- after address 2^ADDR_WIDTH-1, move to RUN.
REQ-006 SHALL assert init_done only in RUN, i.e. from cycle 4096 after the first cycle with RST low (default parameters).
REQ-007 SHALL hold req_rdy=0 in INIT.
REQ-008 SHALL, in RUN, compute req_rdy = (occ < 2) | (rsp_vld & rsp_rdy).
- occ = reads in flight + response FIFO entries.
- req_rdy is independent of req_wr.
REQ-009 SHALL, on an accepted write, drive the same cycle: CEN=0, GWEN=0, A=req_addr, D=req_wdata, WEN=~req_wmask.
REQ-010 SHALL, on an accepted read, drive the same cycle: CEN=0, GWEN=1, WEN=all 1, A=req_addr, and mark one read in flight.
REQ-011 SHALL, with no accepted request in RUN, drive CEN=1, GWEN=1, WEN=all 1; A and D don't-care.
REQ-012 SHALL push Q into a 2-entry response FIFO on the cycle after a read access.
- rsp_vld = FIFO non-empty; rsp_rdata = FIFO head.
- Minimum read latency is 2 cycles from acceptance to rsp_vld.
REQ-013 SHALL sustain one read per cycle when rsp_rdy=1 continuously, and SHALL never overflow the FIFO.
REQ-014 SHALL return written data for a read accepted the cycle after a write to the same address; writes produce no response.
REQ-015 SHALL allow a same-cycle FIFO push and pop; occupancy is then unchanged.
REQ-016 SHALL keep rsp_rdata stable while rsp_vld & !rsp_rdy.
REQ-017 SHALL return responses in request order.

Reset
REQ-018 SHALL, while RST=1, drive CEN=1, GWEN=1, WEN=all 1, init_done=0, req_rdy=0, rsp_vld=0.
REQ-019 SHALL, on RST mid-operation (INIT or RUN), discard in-flight reads and FIFO contents and restart INIT at address 0.

Structure
REQ-020 SHALL take from shared package ct_f_spsram_ctrl_pkg:
- state enum {INIT, RUN};
- default ADDR_WIDTH and DATA_WIDTH constants.
REQ-021 SHALL implement the response FIFO as sub-module ct_f_spsram_rsp_fifo (depth 2, DATA_WIDTH wide, synchronous active-high reset).
REQ-022 SHALL connect the SRAM port directly to ct_f_spsram_4096x84 pins A/CEN/CLK/D/GWEN/Q/WEN.

Verification
REQ-023 Reset release -> exactly 4096 init writes (A=0..4095, GWEN=0, WEN=0, D=0); init_done=1 at cycle 4096; then read any address -> rsp_rdata=0.
REQ-024 Write addr 0x123 data 0xA5.. mask all 1s, next cycle read 0x123 -> rsp_vld 2 cycles later with data 0xA5...
REQ-025 Write addr 5 all 1s, then write addr 5 data 0 with mask 0x0F, read 5 -> low 4 bits 0, other bits 1.
REQ-026 Back-to-back reads 0..15 with rsp_rdy=1 -> req_rdy never drops; 16 in-order responses on consecutive cycles.
REQ-027 Three reads with rsp_rdy=0 -> req_rdy=0 after the 2nd accept; head data held stable; rsp_rdy=1 drains in order and no response is lost.
REQ-028 Assert RST for one cycle with 2 reads outstanding -> rsp_vld=0 next cycle; INIT restarts at A=0; init_done=0.

Source files
------------

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM controller family.
package ct_f_spsram_ctrl_pkg;
  localparam int CT_ADDR_WIDTH = 12;
  localparam int CT_DATA_WIDTH = 84;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/ct_f_spsram_4096x84_ctrl_if.sv
// Request/response bus of the SRAM controller; master is the client, slave the controller.
interface ct_f_spsram_4096x84_ctrl_if
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = CT_ADDR_WIDTH,
  parameter int DATA_WIDTH = CT_DATA_WIDTH
) ();
  logic                  init_done;
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  init_done, req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output init_done, req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Two-entry response FIFO; head is presented directly so it stays put while not popped.
module ct_f_spsram_rsp_fifo
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] entry_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign vld   = (count_reg != 2'd0);
  assign head  = entry_reg[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/ct_f_spsram_4096x84_ctrl.sv
// Controller for a 4096x84 single-port SRAM: clears the array after reset, then
// serves a valid/ready request port with in-order, back-pressured read responses.
module ct_f_spsram_4096x84_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = CT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = CT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  ct_f_spsram_4096x84_ctrl_if.slave bus,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] Q
);
  state_e                state_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic                  rd_pend_reg;
  logic [1:0]            fifo_cnt;
  logic                  fifo_vld;
  logic                  fifo_pop;
  logic                  run;
  logic                  req_fire;
  logic                  rd_fire;
  logic [1:0]            occ;

  // Outputs are gated by RST so a mid-operation reset silences the port immediately.
  assign run           = (state_reg == RUN) && !RST;
  assign occ           = fifo_cnt + {1'b0, rd_pend_reg};
  assign bus.rsp_vld   = fifo_vld && !RST;
  assign fifo_pop      = bus.rsp_vld && bus.rsp_rdy;
  assign bus.req_rdy   = run && ((occ < 2'd2) || fifo_pop);
  assign bus.init_done = run;
  assign req_fire      = bus.req_vld && bus.req_rdy;
  assign rd_fire       = req_fire && !bus.req_wr;

  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = bus.req_addr;
    D    = bus.req_wdata;
    if (!RST && state_reg == INIT) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
      A    = cnt_reg;
      D    = INIT_VAL;
    end else if (req_fire) begin
      CEN = 1'b0;
      if (bus.req_wr) begin
        GWEN = 1'b0;
        WEN  = ~bus.req_wmask;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= INIT;
      cnt_reg     <= '0;
      rd_pend_reg <= 1'b0;
    end else begin
      rd_pend_reg <= rd_fire;
      if (state_reg == INIT) begin
        cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
        if (&cnt_reg) begin
          state_reg <= RUN;
        end
      end
    end
  end

  // Q is valid the cycle after a read access, which is exactly when rd_pend_reg is set.
  ct_f_spsram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk      (CLK),
    .srst     (RST),
    .push     (rd_pend_reg),
    .push_data(Q),
    .pop      (fifo_pop),
    .vld      (fifo_vld),
    .head     (bus.rsp_rdata),
    .count    (fifo_cnt)
  );
endmodule
